// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream link: one producer (master) driving one consumer (slave).
interface axis_pkt_fifo_if #(
    parameter int P_DATA_WIDTH = 16
);
    logic                    tvalid;
    logic                    tready;
    logic [P_DATA_WIDTH-1:0] tdata;
    logic                    tlast;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Synchronous AXI-Stream FIFO with fill status and optional store-and-forward
// packet mode; a packet larger than the FIFO falls back to cut-through.
module axis_pkt_fifo #(
    parameter int P_DATA_WIDTH   = 16,
    parameter int P_FIFO_DEPTH   = 16,
    parameter int P_PACKET_MODE  = 0,
    parameter int P_ALMOST_FULL  = P_FIFO_DEPTH - 2,
    parameter int P_ALMOST_EMPTY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    axis_pkt_fifo_if.slave                  s_axis,
    axis_pkt_fifo_if.master                 m_axis,
    output logic [$clog2(P_FIFO_DEPTH):0]   fill_level,
    output logic                            almost_full,
    output logic                            almost_empty
);
    localparam int LP_AW = $clog2(P_FIFO_DEPTH);
    localparam int LP_PW = LP_AW + 1;
    localparam logic [LP_PW-1:0] LP_FULL = LP_PW'(P_FIFO_DEPTH);
    localparam logic [LP_PW-1:0] LP_ONE  = LP_PW'(1);

    generate
        if (!(P_ALMOST_EMPTY < P_ALMOST_FULL && P_ALMOST_FULL <= P_FIFO_DEPTH) ||
            P_FIFO_DEPTH < 4 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0 ||
            P_DATA_WIDTH < 1) begin : g_bad_param
            $error("axis_pkt_fifo: illegal parameter combination");
        end
    endgenerate

    logic [P_DATA_WIDTH:0] r_mem [P_FIFO_DEPTH];
    logic [LP_PW-1:0]      r_wr, r_rd, r_cm, r_fill;
    logic                  r_ovs;

    logic                  w_push, w_pop, w_full, w_ovs_set;
    logic [LP_PW-1:0]      w_readable;
    logic [P_DATA_WIDTH:0] w_rd_word;

    assign w_full        = (r_fill == LP_FULL);
    assign w_readable    = r_cm - r_rd;
    assign s_axis.tready = ~rst & ~w_full;
    assign m_axis.tvalid = ~rst & (w_readable != '0);
    assign w_push        = s_axis.tvalid & s_axis.tready;
    assign w_pop         = m_axis.tvalid & m_axis.tready;

    // Show-ahead read; the entry under r_rd is only rewritten when the FIFO is empty.
    assign w_rd_word     = r_mem[r_rd[LP_AW-1:0]];
    assign m_axis.tdata  = w_rd_word[P_DATA_WIDTH-1:0];
    assign m_axis.tlast  = w_rd_word[P_DATA_WIDTH];

    assign fill_level    = r_fill;
    assign almost_full   = (r_fill >= LP_PW'(P_ALMOST_FULL));
    assign almost_empty  = (r_fill <= LP_PW'(P_ALMOST_EMPTY));

    // Full with nothing committed means the packet cannot fit: release what is stored.
    assign w_ovs_set = (P_PACKET_MODE != 0) & w_full & (r_cm == r_rd) & ~r_ovs;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[LP_AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cm   <= '0;
            r_fill <= '0;
            r_ovs  <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + LP_ONE;
            if (w_pop)  r_rd <= r_rd + LP_ONE;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + LP_ONE;
                2'b01:   r_fill <= r_fill - LP_ONE;
                default: r_fill <= r_fill;
            endcase
            if (P_PACKET_MODE == 0) begin
                if (w_push) r_cm <= r_wr + LP_ONE;
            end else if (w_ovs_set) begin
                r_cm  <= r_wr;
                r_ovs <= 1'b1;
            end else if (w_push && (s_axis.tlast || r_ovs)) begin
                r_cm <= r_wr + LP_ONE;
                if (s_axis.tlast) r_ovs <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench: a cut-through and a packet-mode FIFO driven from vector
// tables plus hand-written multi-cycle sequences.
module tb_axis_pkt_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_pkt_fifo_if #(.P_DATA_WIDTH(16)) ct_s ();
    axis_pkt_fifo_if #(.P_DATA_WIDTH(16)) ct_m ();
    axis_pkt_fifo_if #(.P_DATA_WIDTH(16)) pk_s ();
    axis_pkt_fifo_if #(.P_DATA_WIDTH(16)) pk_m ();
    logic [4:0] ct_fill, pk_fill;
    logic       ct_af, ct_ae, pk_af, pk_ae;

    axis_pkt_fifo #(.P_PACKET_MODE(0)) u_ct (
        .clk(clk), .rst(rst), .s_axis(ct_s), .m_axis(ct_m),
        .fill_level(ct_fill), .almost_full(ct_af), .almost_empty(ct_ae));
    axis_pkt_fifo #(.P_PACKET_MODE(1)) u_pk (
        .clk(clk), .rst(rst), .s_axis(pk_s), .m_axis(pk_m),
        .fill_level(pk_fill), .almost_full(pk_af), .almost_empty(pk_ae));

    int n_chk = 0;
    int n_err = 0;

    // Selected DUT's observable outputs.
    bit         sel;
    logic       o_v, o_l, o_srdy, o_af, o_ae;
    logic [15:0] o_d;
    logic [4:0] o_fill;
    always_comb begin
        if (sel) begin
            o_v = pk_m.tvalid; o_d = pk_m.tdata; o_l = pk_m.tlast;
            o_srdy = pk_s.tready; o_fill = pk_fill; o_af = pk_af; o_ae = pk_ae;
        end else begin
            o_v = ct_m.tvalid; o_d = ct_m.tdata; o_l = ct_m.tlast;
            o_srdy = ct_s.tready; o_fill = ct_fill; o_af = ct_af; o_ae = ct_ae;
        end
    end

    typedef struct {
        bit         sel;
        logic       sv;
        logic [15:0] sd;
        logic       sl, mr;
        logic       ev;
        logic [15:0] ed;
        logic       el;
        int         efill;
        logic       esr, eaf, eae;
    } vec_t;
    vec_t tbl[$];

    function automatic void addv(bit s, logic sv, logic [15:0] sd, logic sl, logic mr,
                                 logic ev, logic [15:0] ed, logic el, int efill,
                                 logic esr, logic eaf, logic eae);
        vec_t v;
        v.sel = s; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.ev = ev; v.ed = ed; v.el = el; v.efill = efill;
        v.esr = esr; v.eaf = eaf; v.eae = eae;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input logic sv, input logic [15:0] sd,
                         input logic sl, input logic mr);
        sel = s;
        if (s) begin
            pk_s.tvalid = sv; pk_s.tdata = sd; pk_s.tlast = sl; pk_m.tready = mr;
            ct_s.tvalid = 1'b0; ct_s.tdata = '0; ct_s.tlast = 1'b0; ct_m.tready = 1'b0;
        end else begin
            ct_s.tvalid = sv; ct_s.tdata = sd; ct_s.tlast = sl; ct_m.tready = mr;
            pk_s.tvalid = 1'b0; pk_s.tdata = '0; pk_s.tlast = 1'b0; pk_m.tready = 1'b0;
        end
    endtask

    task automatic chk_status(input string tag, input logic ev, input int efill,
                              input logic esr, input logic eaf, input logic eae);
        chk({tag, "_tvalid"}, int'(o_v), int'(ev));
        chk({tag, "_fill"},   int'(o_fill), efill);
        chk({tag, "_tready"}, int'(o_srdy), int'(esr));
        chk({tag, "_afull"},  int'(o_af), int'(eaf));
        chk({tag, "_aempty"}, int'(o_ae), int'(eae));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 16'h0, 0, 0);
        pk_s.tvalid = 1'b0; pk_s.tdata = '0; pk_s.tlast = 1'b0; pk_m.tready = 1'b0;

        // Cut-through: fill to 16 with the output stalled.
        for (int k = 0; k < 16; k++)
            addv(0, 1, 16'(k + 1), k == 15, 0, k > 0, 16'h0001, 0, k, 1, k >= 14, k <= 2);
        // Full: a push attempted alongside the first pop must not be taken.
        addv(0, 1, 16'h0099, 0, 1, 1, 16'h0001, 0, 16, 0, 1, 0);
        for (int k = 17; k < 32; k++)
            addv(0, 0, 16'h0, 0, 1, 1, 16'(k - 15), (k - 15) == 16, 32 - k, 1,
                 (32 - k) >= 14, (32 - k) <= 2);
        addv(0, 0, 16'h0, 0, 1, 0, 16'h0, 0, 0, 1, 0, 1);
        // Cut-through streaming, wrapping the pointers.
        for (int i = 0; i < 40; i++)
            addv(0, 1, 16'(16'h0100 + i), 0, 1, i > 0, 16'(16'h0100 + i - 1), 0,
                 (i > 0) ? 1 : 0, 1, 0, 1);
        addv(0, 0, 16'h0, 0, 1, 1, 16'h0127, 0, 1, 1, 0, 1);
        addv(0, 0, 16'h0, 0, 1, 0, 16'h0, 0, 0, 1, 0, 1);
        // Packet mode: 4-word packet held back until its last beat is stored.
        for (int c = 0; c < 4; c++)
            addv(1, 1, 16'(16'h00A0 + c), c == 3, 1, 0, 16'h0, 0, c, 1, 0, c <= 2);
        addv(1, 0, 16'h0, 0, 1, 1, 16'h00A0, 0, 4, 1, 0, 0);
        addv(1, 0, 16'h0, 0, 1, 1, 16'h00A1, 0, 3, 1, 0, 0);
        addv(1, 0, 16'h0, 0, 1, 1, 16'h00A2, 0, 2, 1, 0, 1);
        addv(1, 0, 16'h0, 0, 1, 1, 16'h00A3, 1, 1, 1, 0, 1);
        addv(1, 0, 16'h0, 0, 1, 0, 16'h0, 0, 0, 1, 0, 1);

        // Reset state, during reset and on the first cycle after.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk_status($sformatf("rst_hold%0d", s), 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk_status($sformatf("rst_after%0d", s), 0, 0, 1, 0, 1);
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].sel, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
            #1;
            chk_status($sformatf("v%0d", i), tbl[i].ev, tbl[i].efill, tbl[i].esr,
                       tbl[i].eaf, tbl[i].eae);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_tdata", i), int'(o_d), int'(tbl[i].ed));
                chk($sformatf("v%0d_tlast", i), int'(o_l), int'(tbl[i].el));
            end
        end

        // Packet mode: 20-word packet into 16 entries forces a commit at full.
        begin
            int nxt = 1, got = 1, first_out = -1, last_out = -1;
            for (int cyc = 0; cyc < 80 && got <= 20; cyc++) begin
                @(negedge clk);
                drive(1, nxt <= 20, 16'(16'h0B00 + nxt), nxt == 20, 1);
                #1;
                if (cyc == 16) begin
                    chk("ovs_full_fill", int'(o_fill), 16);
                    chk("ovs_full_tready", int'(o_srdy), 0);
                end
                if (o_v) begin
                    chk($sformatf("ovs_data%0d", got), int'(o_d), 16'h0B00 + got);
                    chk($sformatf("ovs_last%0d", got), int'(o_l), int'(got == 20));
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    got++;
                end
                if (o_srdy && nxt <= 20) nxt++;
            end
            chk("ovs_count", got - 1, 20);
            chk("ovs_first_cycle", first_out, 17);
            chk("ovs_last_cycle", last_out, 36);
            @(negedge clk);
            drive(1, 0, 16'h0, 0, 1);
            #1;
            chk_status("ovs_drained", 0, 0, 1, 0, 1);
        end

        // Cut-through under random backpressure.
        begin
            int sent = 0, rcv = 0;
            logic pend = 1'b0, hold = 1'b0, mr;
            logic [15:0] pd = '0;
            logic pl = 1'b0;
            for (int cyc = 0; cyc < 2000 && rcv < 30; cyc++) begin
                @(negedge clk);
                if (!pend && sent < 30 && $urandom_range(0, 3) != 0) pend = 1'b1;
                mr = 1'($urandom_range(0, 1));
                drive(0, pend, 16'(16'h0300 + sent), (sent % 5) == 4, mr);
                #1;
                if (hold) begin
                    chk($sformatf("bp_hold_valid%0d", rcv), int'(o_v), 1);
                    chk($sformatf("bp_hold_data%0d", rcv), int'(o_d), int'(pd));
                    chk($sformatf("bp_hold_last%0d", rcv), int'(o_l), int'(pl));
                end
                if (o_v && mr) begin
                    chk($sformatf("bp_data%0d", rcv), int'(o_d), 16'h0300 + rcv);
                    chk($sformatf("bp_last%0d", rcv), int'(o_l), int'((rcv % 5) == 4));
                    rcv++;
                end
                hold = o_v && !mr;
                pd = o_d;
                pl = o_l;
                if (pend && o_srdy) begin
                    sent++;
                    pend = 1'b0;
                end
            end
            chk("bp_count", rcv, 30);
            @(negedge clk);
            drive(0, 0, 16'h0, 0, 1);
            #1;
            chk_status("bp_drained", 0, 0, 1, 0, 1);
        end

        // Packet mode: reset part-way through an 8-word packet.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1, 1, 16'(16'h00D0 + c), 0, 1);
            #1;
            chk($sformatf("mid_hidden%0d", c), int'(o_v), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 16'h0, 0, 1);
        #1;
        chk("mid_rst_tvalid", int'(o_v), 0);
        chk("mid_rst_tready", int'(o_srdy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_status("mid_after", 0, 0, 1, 0, 1);
        begin
            int nxt = 0, got = 0;
            for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
                if (cyc > 0) @(negedge clk);
                drive(1, nxt < 3, 16'(16'h00E0 + nxt), nxt == 2, 1);
                #1;
                if (o_v) begin
                    chk($sformatf("mid_data%0d", got), int'(o_d), 16'h00E0 + got);
                    chk($sformatf("mid_last%0d", got), int'(o_l), int'(got == 2));
                    got++;
                end
                if (o_srdy && nxt < 3) nxt++;
            end
            chk("mid_count", got, 3);
            @(negedge clk);
            drive(1, 0, 16'h0, 0, 1);
            #1;
            chk_status("mid_drained", 0, 0, 1, 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Parametrised synchronous AXI-Stream FIFO; next-generation stream buffer for the data path.
- Adds generic data width and depth, TLAST pass-through, fill-level and almost-full/almost-empty status.
- Adds an optional packet (store-and-forward) mode: a packet is presented downstream only once its TLAST beat has been stored.
- Sits between any AXI-Stream producer/consumer pair in the clk domain.

Parameters:
- P_DATA_WIDTH, 16, width of TDATA in bits (>=1).
- P_FIFO_DEPTH, 16, number of entries; power of two, >=4.
- P_PACKET_MODE, 0, 0 = cut-through (word-level), 1 = store-and-forward on TLAST.
- P_ALMOST_FULL, P_FIFO_DEPTH-2, almost_full asserted when fill_level >= this value.
- P_ALMOST_EMPTY, 2, almost_empty asserted when fill_level <= this value.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axis_tvalid  in  1  upstream word valid.
- s_axis_tready  out  1  FIFO can accept a word.
- s_axis_tdata  in  P_DATA_WIDTH  upstream data.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tdata  out  P_DATA_WIDTH  output data.
- m_axis_tlast  out  1  output last flag.
- fill_level  out  $clog2(P_FIFO_DEPTH)+1  stored words, including uncommitted words.
- almost_full  out  1  fill_level >= P_ALMOST_FULL.
- almost_empty  out  1  fill_level <= P_ALMOST_EMPTY.

Behaviour:
- Storage: DEPTH x (P_DATA_WIDTH+1) RAM holding {tlast, tdata}. Write pointer wr_ptr, read pointer rd_ptr and commit pointer cm_ptr, each $clog2(DEPTH)+1 bits (extra wrap bit). Pointers wrap naturally at DEPTH.
- Push = s_axis_tvalid & s_axis_tready.
- Pop = m_axis_tvalid & m_axis_tready.
- fill_level = wr_ptr - rd_ptr, registered; it reaches DEPTH exactly when full.
- s_axis_tready = (fill_level != DEPTH), from registered state.
  - No push while full, even if a pop occurs in the same cycle; ready returns the cycle after the pop.
- Readable words = cm_ptr - rd_ptr.
  - m_axis_tvalid = readable != 0.
  - m_axis_tdata/tlast are a show-ahead read of RAM[rd_ptr]. They must hold stable while tvalid=1 and tready=0.
- Cut-through mode (P_PACKET_MODE=0): cm_ptr follows wr_ptr on every push. A word pushed at cycle N gives m_axis_tvalid=1 at N+1.
- Packet mode (P_PACKET_MODE=1):
  - cm_ptr <= wr_ptr+1 on a push with tlast=1; otherwise cm_ptr holds.
  - The first word of a packet is visible at cycle N+1, where N is the cycle its tlast beat is pushed.
- Oversize packet (packet mode only):
  - Condition: FIFO full and cm_ptr == rd_ptr, i.e. nothing committed.
  - Internal flag ovs sets and cm_ptr <= wr_ptr, which forces a commit.
  - While ovs=1, every push also commits (cut-through) until the push carrying tlast=1, which clears ovs.
  - No deadlock and no data loss.
- Simultaneous push and pop: both pointers advance and fill_level is unchanged. Pushing into an empty FIFO while popping is not possible, because tvalid=0.
- Flags almost_full and almost_empty are derived combinationally from registered fill_level and are consistent with it in the same cycle.
- Reset, while rst=1 and on the first cycle after:
  - Pointers=0, ovs=0, fill_level=0.
  - m_axis_tvalid=0, almost_full=0, almost_empty=1.
  - s_axis_tready=0 while rst=1, and 1 the cycle after deassertion.
- Reset mid-operation discards all contents, including a partially received packet. m_axis_tvalid drops in the same cycle rst is sampled.
- Constraint: P_ALMOST_EMPTY < P_ALMOST_FULL <= P_FIFO_DEPTH; otherwise elaboration error.

Test Plan:
- Defaults, cut-through: push 0x0001..0x0010 back-to-back with m_axis_tready=0.
  - Expect s_axis_tready=0 after 16 pushes, fill_level=16, almost_full=1 from fill_level 14.
  - Then tready=1: data out 0x0001..0x0010 in order, one per cycle; almost_empty=1 at fill_level <=2.
- Streaming: continuous push and pop with tready=1.
  - Expect first output 1 cycle after first push, fill_level steady at 1, throughput 1 word/clk, and wrap past entry 15 with no corruption.
- Packet mode, 4-word packet 0xA0..0xA3 (tlast on 0xA3).
  - Expect m_axis_tvalid=0 until the cycle after 0xA3 is pushed, then 0xA0..0xA3 out with tlast only on 0xA3.
- Packet mode, 20-word packet into depth 16, tready=1.
  - Expect the force-commit at full, all 20 words delivered in order, tlast on word 20, and no stall beyond the full/empty cycles.
- Backpressure: toggle m_axis_tready randomly.
  - Expect tdata/tlast stable while tvalid=1 and tready=0, and no loss or duplication.
- Assert rst after 5 words of an 8-word packet.
  - Expect fill_level=0, m_axis_tvalid=0, s_axis_tready=1 after reset.
  - A new packet is then delivered correctly with no stale words.
